stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Single-clock multicycle controller for the non-pipelined LEGv8 datapath. It replaces the delayed-clock phasing (instruction-memory, decode-read, memory and decode-write clocks) with one-hot stage enables, all on one clock. It sequences each instruction through fetch, decode, execute, memory and writeback. It waits on a memory ready handshake, supports run, single-step and halt, and flags memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max MEMORY-state wait cycles before error; legal range 1..255.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising clk edge
run  in  1  level; free-running execution while high
step  in  1  rising edge executes exactly one instruction when run low
halt_instr  in  1  decoded HALT opcode; valid in DECODE
mem_access  in  1  mem_read|mem_write from decode; valid in DECODE
mem_ready  in  1  data memory completion; sampled in MEMORY
fetch_en  out  1  instruction memory read/latch strobe
decode_en  out  1  register file read strobe
execute_en  out  1  ALU/sreg update strobe
mem_en  out  1  high for every MEMORY cycle; branch pc_src evaluated here
mem_req  out  1  high in MEMORY while access pending and not ready
writeback_en  out  1  register file write strobe
pc_en  out  1  PC register update (pc+4 or branch target)
busy  out  1  state not IDLE/HALT/ERROR
halted  out  1  state == HALT
mem_error  out  1  sticky timeout flag
state  out  3  current state encoding
instr_count  out  CNT_W  retired instructions (optional feature)
stall_count  out  CNT_W  MEMORY wait cycles (optional feature)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- Outputs are Moore, decoded from the registered state. Each enable is high only in its own state. pc_en and writeback_en are high only in WRITEBACK.
- Reset (reset==0 at an edge): state=IDLE, all outputs 0, internal flags and counters 0, step edge detector cleared. Reset mid-instruction abandons the instruction; no further strobes are issued.
- IDLE: run=1 -> FETCH. Else step rising edge (step=1, step_d=0) -> FETCH. Otherwise stay. Step while run=1 is ignored.
- FETCH -> DECODE -> EXECUTE -> MEMORY, one cycle each.
- DECODE: latches mem_access into acc_q and halt_instr into halt_q.
- MEMORY:
  - acc_q=0: one cycle, then WRITEBACK.
  - acc_q=1: mem_req=mem_en=1. mem_ready=1 -> WRITEBACK. Otherwise the wait counter increments.
  - Wait counter reaches MEM_TIMEOUT with mem_ready still 0 -> ERROR. mem_ready arriving on the same cycle the count reaches MEM_TIMEOUT wins (-> WRITEBACK).
  - Wait counter clears on MEMORY entry.
- WRITEBACK: halt_q -> HALT. Else run=1 -> FETCH. Else -> IDLE. The HALT instruction still gets its pc_en/writeback_en.
- HALT and ERROR are terminal until reset. mem_error=1 in ERROR.
- Latency: 5 cycles per instruction plus the memory wait cycles. mem_ready high on the first MEMORY cycle adds no wait.
- run dropping mid-instruction completes the current instruction, then goes to IDLE.

Optional Feature:
- Macro: STAGE_SEQ_PERF_EN.
- Defined:
  - instr_count increments on each WRITEBACK cycle.
  - stall_count increments on each MEMORY cycle with mem_req=1.
  - Both wrap at 2^CNT_W and clear on reset.
- Undefined: both ports driven constant 0; no counter flops.

Decomposition:
- Shared package seq_pkg: enum seq_state_t (3-bit, encodings above) and localparam SEQ_STATE_W=3. Datapath and bench reuse both.
- One sub-module, seq_timeout_ctr: clear/enable/terminal-count counter, width clog2(MEM_TIMEOUT+1). It is also reused by the optional counters with width CNT_W.

Test Plan:
- Reset low 2 cycles, then run=1, mem_access=0: strobes FETCH..WRITEBACK at cycles 1-5, pc_en at cycle 5, repeats every 5 cycles, state=1 on cycle 6.
- run=0, step pulsed once: exactly one instruction (5 strobes), then IDLE with busy=0. Step held high 20 cycles: still only one instruction.
- mem_access=1, mem_ready rises after 3 MEMORY cycles: mem_req high 3 cycles, instruction takes 8 cycles, stall_count=3 with STAGE_SEQ_PERF_EN.
- MEM_TIMEOUT=4, mem_ready stuck 0: ERROR entered after 4 wait cycles, mem_error=1, no writeback_en, stays until reset.
- halt_instr=1 in DECODE of the 3rd instruction: that instruction's writeback_en/pc_en fire, then halted=1, instr_count=3, run ignored.
- Reset asserted during MEMORY wait: next cycle state=IDLE, all strobes 0, counters 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encoding for the LEGv8 multicycle stage sequencer.
package seq_pkg;
  localparam int unsigned SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } seq_state_t;
endpackage

// File: rtl/seq_timeout_ctr.sv
// Clearable up-counter with enable and a terminal-count flag at TC.
module seq_timeout_ctr #(
  parameter int unsigned W  = 4,
  parameter int unsigned TC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);
  localparam logic [W-1:0] TC_V = W'(TC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == TC_V);
endmodule

// File: rtl/stage_sequencer.sv
// Single-clock multicycle stage sequencer for the LEGv8 datapath.
// Optional performance counters enabled by defining STAGE_SEQ_PERF_EN.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_instr,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_en,
  output logic             mem_req,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic             mem_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t      state_q, state_d;
  logic            step_d, acc_q, halt_q, err_q;
  logic            wait_tc;
  logic [TO_W-1:0] wait_cnt_unused;

  // Terminal count sits one below the limit so the wait that would reach
  // MEM_TIMEOUT is the one that diverts to ERROR (unless ready arrives).
  seq_timeout_ctr #(
    .W  (TO_W),
    .TC (MEM_TIMEOUT - 1)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == EXECUTE),
    .en    (state_q == MEMORY && acc_q && !mem_ready),
    .count (wait_cnt_unused),
    .tc    (wait_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (run || (step && !step_d)) state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = MEMORY;
      MEMORY: begin
        if (!acc_q || mem_ready) state_d = WRITEBACK;
        else if (wait_tc)        state_d = ERROR;
      end
      WRITEBACK: begin
        if (halt_q)   state_d = HALT;
        else if (run) state_d = FETCH;
        else          state_d = IDLE;
      end
      HALT:      state_d = HALT;
      ERROR:     state_d = ERROR;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      step_d  <= 1'b0;
      acc_q   <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_d  <= step;
      if (state_q == DECODE) begin
        acc_q  <= mem_access;
        halt_q <= halt_instr;
      end
      if (state_d == ERROR) err_q <= 1'b1;
    end
  end

  assign fetch_en     = (state_q == FETCH);
  assign decode_en    = (state_q == DECODE);
  assign execute_en   = (state_q == EXECUTE);
  assign mem_en       = (state_q == MEMORY);
  assign mem_req      = mem_en && acc_q && !mem_ready;
  assign writeback_en = (state_q == WRITEBACK);
  assign pc_en        = (state_q == WRITEBACK);
  assign busy         = (state_q != IDLE) && (state_q != HALT) && (state_q != ERROR);
  assign halted       = (state_q == HALT);
  assign mem_error    = err_q;
  assign state        = state_q;

`ifdef STAGE_SEQ_PERF_EN
  logic instr_tc_unused, stall_tc_unused;

  seq_timeout_ctr #(
    .W  (CNT_W),
    .TC (0)
  ) u_instr_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (writeback_en),
    .count (instr_count),
    .tc    (instr_tc_unused)
  );

  seq_timeout_ctr #(
    .W  (CNT_W),
    .TC (0)
  ) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (mem_req),
    .count (stall_count),
    .tc    (stall_tc_unused)
  );
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-cycle plan built from instruction-level rules.
module tb_stage_sequencer;
  import seq_pkg::*;

  localparam int unsigned T     = 4;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic reset, run, step, halt_instr, mem_access, mem_ready;
  logic fetch_en, decode_en, execute_en, mem_en, mem_req, writeback_en, pc_en;
  logic busy, halted, mem_error;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count, stall_count;
  logic [9:0]       outs;

  stage_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_instr(halt_instr),
    .mem_access(mem_access), .mem_ready(mem_ready), .fetch_en(fetch_en),
    .decode_en(decode_en), .execute_en(execute_en), .mem_en(mem_en),
    .mem_req(mem_req), .writeback_en(writeback_en), .pc_en(pc_en), .busy(busy),
    .halted(halted), .mem_error(mem_error), .state(state),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign outs = {fetch_en, decode_en, execute_en, mem_en, mem_req,
                 writeback_en, pc_en, busy, halted, mem_error};

  typedef struct {
    logic [2:0] st;
    bit run, step, acc, halt, rdy, lacc;
  } cyc_t;

  cyc_t            plan[$];
  int unsigned     n_tests = 0, n_fail = 0;
  longint unsigned exp_instr = 0, exp_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input bit r, input bit s, input bit a,
                      input bit h, input bit rd, input bit la);
    cyc_t e;
    e.st = st; e.run = r; e.step = s; e.acc = a; e.halt = h; e.rdy = rd; e.lacc = la;
    plan.push_back(e);
  endtask

  task automatic add_idle(input int n, input bit r, input bit s);
    for (int i = 0; i < n; i++) push(IDLE, r, s, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic add_term(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) push(st, rb(), rb(), rb(), rb(), rb(), 1'b0);
  endtask

  // One instruction: w = MEMORY cycles before ready; w >= T ends in ERROR.
  task automatic add_instr(input bit acc, input int w, input bit halt, input bit r_head,
                           input bit r_tail, input bit s, input int cut);
    int n;
    push(FETCH,   r_head, s, rb(), rb(), rb(), acc);
    push(DECODE,  r_head, s, acc,  halt, rb(), acc);
    push(EXECUTE, r_tail, s, rb(), rb(), rb(), acc);
    if (!acc) begin
      push(MEMORY, r_tail, s, rb(), rb(), rb(), acc);
    end else begin
      n = (w >= int'(T)) ? int'(T) : w + 1;
      if (cut > 0 && cut < n) n = cut;
      for (int k = 0; k < n; k++) push(MEMORY, r_tail, s, rb(), rb(), bit'(k >= w), acc);
    end
    if (cut > 0 || (acc && w >= int'(T))) return;
    push(WRITEBACK, r_tail, s, rb(), rb(), rb(), acc);
  endtask

  task automatic play();
    cyc_t e;
    logic [9:0] expv;
    bit mr;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(negedge clk);
      run = e.run; step = e.step; mem_access = e.acc; halt_instr = e.halt; mem_ready = e.rdy;
      #1;
      mr = (e.st == MEMORY) && e.lacc && !e.rdy;
      expv = {e.st == FETCH, e.st == DECODE, e.st == EXECUTE, e.st == MEMORY, mr,
              e.st == WRITEBACK, e.st == WRITEBACK, (e.st >= FETCH) && (e.st <= WRITEBACK),
              e.st == HALT, e.st == ERROR};
      check("state", 64'(state), 64'(e.st));
      check("outs", 64'(outs), 64'(expv));
`ifdef STAGE_SEQ_PERF_EN
      check("instr_count", 64'(instr_count), 64'(exp_instr[CNT_W-1:0]));
      check("stall_count", 64'(stall_count), 64'(exp_stall[CNT_W-1:0]));
`else
      check("instr_count", 64'(instr_count), 64'(0));
      check("stall_count", 64'(stall_count), 64'(0));
`endif
      if (e.st == WRITEBACK) exp_instr++;
      if (mr) exp_stall++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0; step = 1'b0;
    mem_access = 1'b0; halt_instr = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 64'(state), 64'(0));
    check("reset_outs", 64'(outs), 64'(0));
    check("reset_instr", 64'(instr_count), 64'(0));
    check("reset_stall", 64'(stall_count), 64'(0));
    exp_instr = 0;
    exp_stall = 0;
    reset = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit acc, halt, rt;
    reset = 1'b0; run = 1'b0; step = 1'b0;
    mem_access = 1'b0; halt_instr = 1'b0; mem_ready = 1'b0;

    // Free run, then run dropped mid-instruction
    do_reset();
    add_idle(1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add_instr(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_instr(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_idle(3, 1'b0, 1'b0);
    // Single step pulse, then step held for 20 cycles
    push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_instr(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_idle(3, 1'b0, 1'b0);
    push(IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_instr(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add_idle(20, 1'b0, 1'b1);
    add_idle(2, 1'b0, 1'b0);
    // Memory waits: 3 stalls, zero stalls, and ready on the last allowed cycle
    add_idle(1, 1'b1, 1'b0);
    add_instr(1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_instr(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_instr(1'b1, int'(T) - 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_idle(2, 1'b0, 1'b0);
    play();

    // Timeout into ERROR, terminal until reset
    do_reset();
    add_idle(1, 1'b1, 1'b0);
    add_instr(1'b1, int'(T), 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_term(ERROR, 8);
    play();

    // HALT on the third instruction
    do_reset();
    add_idle(1, 1'b1, 1'b0);
    add_instr(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_instr(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    add_instr(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    add_term(HALT, 8);
    play();

    // Reset while waiting in MEMORY
    do_reset();
    add_idle(1, 1'b1, 1'b0);
    add_instr(1'b1, 99, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    play();
    do_reset();

    // Randomized programs
    for (int round = 0; round < 12; round++) begin
      do_reset();
      add_idle(int'($urandom_range(0, 2)), 1'b0, 1'b0);
      if (rb()) push(IDLE, 1'b1, rb(), rb(), rb(), rb(), 1'b0);
      else      push(IDLE, 1'b0, 1'b1, rb(), rb(), rb(), 1'b0);
      for (int n = 0; n < 20; n++) begin
        acc  = rb();
        w    = ($urandom_range(0, 11) == 0) ? int'(T) : int'($urandom_range(0, T - 1));
        halt = ($urandom_range(0, 19) == 0);
        rt   = ($urandom_range(0, 3) != 0);
        add_instr(acc, w, halt, rb(), rt, rb(), 0);
        if (acc && w >= int'(T)) begin add_term(ERROR, 3); break; end
        if (halt) begin add_term(HALT, 3); break; end
        if (!rt) begin
          add_idle(1 + int'($urandom_range(0, 2)), 1'b0, 1'b0);
          if (rb()) push(IDLE, 1'b1, rb(), rb(), rb(), rb(), 1'b0);
          else      push(IDLE, 1'b0, 1'b1, rb(), rb(), rb(), 1'b0);
        end
      end
      play();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
